// File: rtl/csi_pkg.sv
// Shared definitions for the CSI packetizer.
// Holds the default frame size, stream word width, header magic value,
// the read-side FSM state type, the CSI word layout and a saturating
// counter helper.
package csi_pkg;

  localparam int          NUM_SC_DEFAULT = 64;
  localparam int          CSI_W          = 32;
  localparam logic [15:0] HEADER_MAGIC   = 16'hC5A1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } csi_word_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/csi_frame_bank.sv
// Two-bank frame store: simple dual-port RAM of 2*NUM_SC words.
// The address is {bank, idx}. The read port is synchronous, so rdata
// shows the word addressed in the previous cycle.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address {bank, idx}
//   wdata  in   write data
//   raddr  in   read address {bank, idx}
//   rdata  out  registered read data
module csi_frame_bank
  import csi_pkg::*;
#(
  parameter int NUM_SC = NUM_SC_DEFAULT,
  parameter int DW     = CSI_W
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(2*NUM_SC)-1:0]   waddr,
  input  logic [DW-1:0]                 wdata,
  input  logic [$clog2(2*NUM_SC)-1:0]   raddr,
  output logic [DW-1:0]                 rdata
);

  logic [DW-1:0] mem [2*NUM_SC];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/csi_packetizer.sv
// CSI packetizer: stores complete CSI frames in a ping-pong frame store
// and emits each one as {MAGIC, seq} followed by NUM_SC CSI words.
// The input is never back-pressured; frames that find no free bank or
// that have the wrong length are discarded and counted.
// Ports:
//   s00_axis_aclk     in   clock
//   s00_axis_aresetn  in   asynchronous active-low reset
//   s00_axis_tvalid   in   CSI word valid
//   s00_axis_tlast    in   last CSI word of frame
//   s00_axis_tdata    in   CSI word {re, im}
//   s00_axis_tready   out  1 outside reset
//   m00_axis_tvalid   out  packet word valid
//   m00_axis_tlast    out  last word of packet
//   m00_axis_tdata    out  header or CSI word
//   m00_axis_tready   in   DMA ready
//   seq_out           out  sequence number of the next packet to emit
//   drop_count        out  frames dropped for lack of a free bank (saturating)
//   len_err_count     out  frames with bad length (saturating)
module csi_packetizer
  import csi_pkg::*;
#(
  parameter int          NUM_SC = NUM_SC_DEFAULT,
  parameter logic [15:0] MAGIC  = HEADER_MAGIC
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  input  logic              s00_axis_tvalid,
  input  logic              s00_axis_tlast,
  input  logic [CSI_W-1:0]  s00_axis_tdata,
  output logic              s00_axis_tready,
  output logic              m00_axis_tvalid,
  output logic              m00_axis_tlast,
  output logic [CSI_W-1:0]  m00_axis_tdata,
  input  logic              m00_axis_tready,
  output logic [15:0]       seq_out,
  output logic [15:0]       drop_count,
  output logic [15:0]       len_err_count
);

  localparam int              IDXW     = $clog2(NUM_SC);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SC - 1);
  localparam logic [IDXW-1:0] PEN_IDX  = IDXW'(NUM_SC - 2);

  // Write side state
  logic             tready_r;
  logic [IDXW-1:0]  wr_idx_r;
  logic             wr_bank_r;
  logic             discard_r;
  logic [15:0]      drop_count_r;
  logic [15:0]      len_err_count_r;
  logic [1:0]       full_r;

  // Read side state
  rd_state_t        state_r;
  logic             tvalid_r;
  logic             tlast_r;
  logic [CSI_W-1:0] tdata_r;
  logic [IDXW-1:0]  out_idx_r;
  logic             rd_bank_r;
  logic [15:0]      seq_r;

  csi_word_t        in_word_s;
  logic             in_hs_s;
  logic             frame_start_s;
  logic             drop_s;
  logic             we_s;
  logic             commit_s;
  logic             release_s;
  logic [1:0]       set_mask_s;
  logic [1:0]       clr_mask_s;
  logic [IDXW-1:0]  rd_idx_s;
  logic [CSI_W-1:0] rd_data_s;

  assign in_word_s = s00_axis_tdata;
  assign in_hs_s   = s00_axis_tvalid & tready_r;

  // Write-side decode: frame start, drop decision, RAM write and commit.
  always_comb begin
    frame_start_s = !discard_r && (wr_idx_r == '0);
    // The writer only ever sees the registered full flag, so a bank
    // released in this same cycle still counts as full.
    drop_s        = in_hs_s && frame_start_s && full_r[wr_bank_r];
    we_s          = in_hs_s && !discard_r && !drop_s;
    commit_s      = we_s && s00_axis_tlast && (wr_idx_r == LAST_IDX);
    release_s     = (state_r == PAYLOAD) && m00_axis_tready && (out_idx_r == LAST_IDX);
  end

  // Per-bank set/clear requests for the full flags.
  always_comb begin
    set_mask_s = 2'b00;
    clr_mask_s = 2'b00;
    if (commit_s) begin
      set_mask_s[wr_bank_r] = 1'b1;
    end else begin
      set_mask_s = 2'b00;
    end
    if (release_s) begin
      clr_mask_s[rd_bank_r] = 1'b1;
    end else begin
      clr_mask_s = 2'b00;
    end
  end

  // Input word tracking, discard mode and error counters.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      tready_r        <= 1'b0;
      wr_idx_r        <= '0;
      wr_bank_r       <= 1'b0;
      discard_r       <= 1'b0;
      drop_count_r    <= 16'd0;
      len_err_count_r <= 16'd0;
    end else begin
      tready_r <= 1'b1;
      if (in_hs_s) begin
        if (discard_r) begin
          // Swallow everything up to and including the next tlast.
          if (s00_axis_tlast) begin
            discard_r <= 1'b0;
          end
        end else if (drop_s) begin
          drop_count_r <= sat_inc(drop_count_r);
          discard_r    <= !s00_axis_tlast;
        end else if (s00_axis_tlast) begin
          wr_idx_r <= '0;
          if (wr_idx_r == LAST_IDX) begin
            wr_bank_r <= ~wr_bank_r;
          end else begin
            len_err_count_r <= sat_inc(len_err_count_r);
          end
        end else if (wr_idx_r == LAST_IDX) begin
          // Frame too long: count now, drop the rest; the bank is reused.
          len_err_count_r <= sat_inc(len_err_count_r);
          discard_r       <= 1'b1;
          wr_idx_r        <= '0;
        end else begin
          wr_idx_r <= wr_idx_r + IDXW'(1);
        end
      end
    end
  end

  // Bank full flags: set on commit, cleared when the last word leaves.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Read address: always point at the word that will be loaded into the
  // output register on the next handshake, so payload streams bubble-free.
  always_comb begin
    rd_idx_s = '0;
    case (state_r)
      IDLE: begin
        rd_idx_s = '0;
      end
      HEADER: begin
        if (m00_axis_tready) begin
          rd_idx_s = IDXW'(1);
        end else begin
          rd_idx_s = '0;
        end
      end
      PAYLOAD: begin
        if (m00_axis_tready) begin
          rd_idx_s = out_idx_r + IDXW'(2);
        end else begin
          rd_idx_s = out_idx_r + IDXW'(1);
        end
      end
      default: begin
        rd_idx_s = '0;
      end
    endcase
  end

  csi_frame_bank #(
    .NUM_SC (NUM_SC),
    .DW     (CSI_W)
  ) u_bank (
    .clk   (s00_axis_aclk),
    .we    (we_s),
    .waddr ({wr_bank_r, wr_idx_r}),
    .wdata (in_word_s),
    .raddr ({rd_bank_r, rd_idx_s}),
    .rdata (rd_data_s)
  );

  // Read-side FSM with registered AXIS outputs.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_r   <= IDLE;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      tdata_r   <= '0;
      out_idx_r <= '0;
      rd_bank_r <= 1'b0;
      seq_r     <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (full_r[rd_bank_r]) begin
            state_r  <= HEADER;
            tvalid_r <= 1'b1;
            tdata_r  <= {MAGIC, seq_r};
            tlast_r  <= 1'b0;
          end
        end
        HEADER: begin
          if (m00_axis_tready) begin
            state_r   <= PAYLOAD;
            tdata_r   <= rd_data_s;
            tlast_r   <= 1'b0;
            out_idx_r <= '0;
          end
        end
        PAYLOAD: begin
          if (m00_axis_tready) begin
            if (out_idx_r == LAST_IDX) begin
              state_r   <= IDLE;
              tvalid_r  <= 1'b0;
              tlast_r   <= 1'b0;
              tdata_r   <= '0;
              rd_bank_r <= ~rd_bank_r;
              seq_r     <= seq_r + 16'd1;
            end else begin
              tdata_r   <= rd_data_s;
              tlast_r   <= (out_idx_r == PEN_IDX);
              out_idx_r <= out_idx_r + IDXW'(1);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s00_axis_tready = tready_r;
  assign m00_axis_tvalid = tvalid_r;
  assign m00_axis_tlast  = tlast_r;
  assign m00_axis_tdata  = tdata_r;
  assign seq_out         = seq_r;
  assign drop_count      = drop_count_r;
  assign len_err_count   = len_err_count_r;

endmodule

// File: tb/tb_csi_packetizer.sv
// Self-checking bench for csi_packetizer: a frame-level model predicts
// the packet stream and counters; a per-cycle compare process checks the
// DUT against it, and directed tests add hand-computed expectations.
module tb_csi_packetizer;

  localparam int          NSC   = 64;
  localparam logic [15:0] MAGIC = 16'hC5A1;

  logic        clk;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic        m_tready;
  logic [15:0] seq_out;
  logic [15:0] drop_count;
  logic [15:0] len_err_count;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;

  // Model state
  logic [32:0] exp_q[$];
  logic [31:0] f_buf[$];
  int occ, m_drop, m_len, m_seq, hdr_seq, f_cnt, up_cnt, pkt_seen;
  bit in_frame, f_drop, stall_prev, rel;
  logic [31:0] prev_data;
  logic        prev_last;

  csi_packetizer dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (aresetn),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tready  (s_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tready  (m_tready),
    .seq_out          (seq_out),
    .drop_count       (drop_count),
    .len_err_count    (len_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Output-ready driver: 0 = held low, 1 = held high, 2 = random.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) m_tready = 1'b0;
      else if (rmode == 1) m_tready = 1'b1;
      else m_tready = ($urandom_range(0, 1) == 1);
    end
  end

  // Frame-level model and per-cycle compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        exp_q.delete();
        f_buf.delete();
        occ = 0; m_drop = 0; m_len = 0; m_seq = 0; hdr_seq = 0;
        f_cnt = 0; up_cnt = 0;
        in_frame = 0; f_drop = 0; stall_prev = 0; rel = 0;
      end else begin
        chk("drop_count", drop_count, m_drop);
        chk("len_err_count", len_err_count, m_len);
        chk("seq_out", seq_out, m_seq);
        if (up_cnt > 0) chk("s_tready", s_tready, 1);
        up_cnt++;
        if (stall_prev) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", m_tdata, prev_data);
          chk("hold_last", m_tlast, prev_last);
        end
        if (m_tvalid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", {m_tlast, m_tdata}, 33'h0_DEAD_BEEF);
          end else begin
            chk("out_word", {m_tlast, m_tdata}, exp_q[0]);
            if (m_tready) begin
              void'(exp_q.pop_front());
              if (m_tlast) rel = 1;
            end
          end
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (s_tvalid && s_tready) begin
          if (!in_frame) begin
            in_frame = 1;
            f_drop   = (occ >= 2);
            f_cnt    = 0;
            f_buf.delete();
            if (f_drop) m_drop = sat16(m_drop);
          end
          f_cnt++;
          if (!f_drop) begin
            if (f_cnt <= NSC) f_buf.push_back(s_tdata);
            if (f_cnt == NSC && !s_tlast) m_len = sat16(m_len);
          end
          if (s_tlast) begin
            in_frame = 0;
            if (!f_drop) begin
              if (f_cnt < NSC) begin
                m_len = sat16(m_len);
              end else if (f_cnt == NSC) begin
                exp_q.push_back({1'b0, MAGIC, hdr_seq[15:0]});
                hdr_seq++;
                foreach (f_buf[i]) exp_q.push_back({(i == NSC - 1), f_buf[i]});
                occ++;
              end
            end
          end
        end
        if (rel) begin
          occ--;
          m_seq = (m_seq + 1) % 65536;
          pkt_seen++;
          rel = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_seq", seq_out, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_len", len_err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = base + i;
      s_tlast  = (i == len - 1);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic expect_header(input string name, input logic [31:0] hdr);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (m_tvalid) seen = 1;
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) chk(name, m_tdata, hdr);
  endtask

  task automatic drain(input string name, input int limit);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid && occ == 0) done = 1;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int p0;
    int gap;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 32'd0;

    // 1: single frame, data = index, ready high
    do_reset();
    rmode = 1;
    send_frame(64, 32'd0);
    @(negedge clk);
    chk("t1_lat_idle", m_tvalid, 0);
    @(negedge clk);
    chk("t1_hdr_valid", m_tvalid, 1);
    chk("t1_hdr", m_tdata, 32'hC5A10000);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("t1_valid", m_tvalid, 1);
      chk("t1_data", m_tdata, k);
      chk("t1_last", m_tlast, (k == 63));
    end
    @(negedge clk);
    chk("t1_seq", seq_out, 16'd1);
    chk("t1_idle", m_tvalid, 0);

    // 2: three frames while the DMA stalls; third finds both banks full
    do_reset();
    rmode = 0;
    p0 = pkt_seen;
    send_frame(64, 32'hA000_0000);
    send_frame(64, 32'hB000_0000);
    send_frame(64, 32'hC000_0000);
    chk("t2_drop", drop_count, 16'd1);
    rmode = 1;
    drain("t2_drain", 1000);
    chk("t2_pkts", pkt_seen - p0, 2);
    chk("t2_seq", seq_out, 16'd2);

    // 3: short frame (tlast on word 40), then a good frame
    do_reset();
    rmode = 1;
    send_frame(41, 32'h3300_0000);
    send_frame(64, 32'h3400_0000);
    expect_header("t3_hdr", 32'hC5A10000);
    drain("t3_drain", 500);
    chk("t3_len", len_err_count, 16'd1);
    chk("t3_seq", seq_out, 16'd1);

    // 4: long frame (70 words), then a good frame
    do_reset();
    rmode = 1;
    send_frame(70, 32'h4400_0000);
    send_frame(64, 32'h4500_0000);
    expect_header("t4_hdr", 32'hC5A10000);
    drain("t4_drain", 500);
    chk("t4_len", len_err_count, 16'd1);
    chk("t4_drop", drop_count, 16'd0);

    // 5: random ready over 20 frames with random gaps
    do_reset();
    rmode = 2;
    p0 = pkt_seen;
    for (int f = 0; f < 20; f++) begin
      send_frame(64, 32'h5000_0000 + (f << 16));
      gap = $urandom_range(0, 70);
      repeat (gap) @(posedge clk);
      #1;
    end
    rmode = 1;
    drain("t5_drain", 1000);
    chk("t5_seq", seq_out, pkt_seen - p0);
    chk("t5_accounted", (pkt_seen - p0) + drop_count, 20);

    // 6: reset in the middle of a payload
    do_reset();
    rmode = 1;
    send_frame(20, 32'h6600_0000);
    send_frame(64, 32'h6700_0000);
    repeat (30) @(negedge clk);
    chk("t6_midpkt", m_tvalid, 1);
    do_reset();
    send_frame(64, 32'h7777_0000);
    expect_header("t6_hdr", 32'hC5A10000);
    drain("t6_drain", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi_packetizer.md
Name: csi_packetizer

Overview:
- Sits directly downstream of the CSI extractor. Consumes its 32-bit CSI AXI-Stream: one frame of NUM_SC words per packet, tlast on the last word, data = {re[15:0], im[15:0]}.
- Buffers complete frames in a two-bank ping-pong store and emits each one to the DMA as a header word followed by the NUM_SC CSI words.
- Never back-pressures the CSI pipeline. Frames that cannot be stored, or that have the wrong length, are discarded and counted.

Parameters:
- NUM_SC, 64, CSI words per frame (power of two, 16..256).
- MAGIC, 16'hC5A1, upper half of the header word.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  1  CSI word valid
- s00_axis_tlast  in  1  last CSI word of frame
- s00_axis_tdata  in  32  CSI word {re, im}
- s00_axis_tready  out  1  tied 1 outside reset
- m00_axis_tvalid  out  1  packet word valid
- m00_axis_tlast  out  1  last word of packet
- m00_axis_tdata  out  32  header or CSI word
- m00_axis_tready  in  1  DMA ready
- seq_out  out  16  sequence number of the next packet to emit
- drop_count  out  16  frames dropped because no bank was free (saturating)
- len_err_count  out  16  frames with bad length (saturating)

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0. s00_axis_tready is 0 during reset and 1 from the first clock after release.
  - Banks empty; wr_bank = rd_bank = 0; counters and seq cleared.
- Write side:
  - Word index wr_idx runs 0..NUM_SC-1. A frame starts on the first accepted word after a tlast, or after reset.
  - At frame start the writer checks the registered full flag of wr_bank. If the bank is full, the whole frame is discarded through its tlast and drop_count increments once.
  - Commit: word NUM_SC-1 arrives with tlast=1. The bank's full flag is set next cycle, wr_bank toggles, wr_idx returns to 0.
  - tlast with wr_idx < NUM_SC-1: frame discarded, len_err_count increments, bank stays empty and is reused.
  - wr_idx = NUM_SC-1 without tlast: len_err_count increments and the block enters discard mode until the next tlast, which is swallowed. The bank stays empty.
  - A drop frame that is also mis-sized counts only in drop_count.
- Read side FSM:
  - IDLE: if bank rd_bank is full, go to HEADER.
  - HEADER: drive tdata = {MAGIC, seq}, tlast = 0. On handshake go to PAYLOAD.
  - PAYLOAD: emit bank words 0..NUM_SC-1 in order, with tlast on word NUM_SC-1. On the final handshake: clear the bank's full flag (visible to the writer next cycle), toggle rd_bank, increment seq (16-bit wrap), return to IDLE.
- Output timing:
  - Storage uses synchronous-read RAM. The read side must prefetch so that, with m00_axis_tready held high, the header and all payload words go out on consecutive cycles with no bubble.
  - m00_axis_tvalid rises 2 cycles after the committing input handshake.
  - One idle cycle is allowed between packets.
- AXIS rules:
  - Once tvalid is asserted, tdata and tlast hold until the handshake.
  - tvalid never drops without a handshake.
- Simultaneous events:
  - Write into one bank while the other is read: fully concurrent.
  - A bank release in the same cycle the writer checks it at frame start is not seen; that frame is dropped.
- Counters saturate at 16'hFFFF.
- Reset mid-packet aborts both sides. The first output after reset is the header with seq 0 of the next fully received frame.

Decomposition:
- Package csi_pkg holds:
  - NUM_SC_DEFAULT and CSI_W = 32
  - HEADER_MAGIC
  - typedef enum rd_state_t {IDLE, HEADER, PAYLOAD}
  - typedef struct csi_word_t {logic [15:0] re, im}
- Sub-module csi_frame_bank: simple dual-port RAM, 2*NUM_SC x 32, one write port and one synchronous read port. Address = {bank, idx}.

Test Plan:
1. Reset release, one 64-word frame (data = index), tready=1 -> output word 0 = 32'hC5A10000, then words 0..63 on consecutive cycles, tlast on word 63, seq_out=1.
2. Three back-to-back frames with tready=0 -> frames 1 and 2 stored, frame 3 dropped. drop_count=1; after tready=1, exactly two packets with headers seq 0 and 1.
3. Frame with tlast at word 40 -> no packet, len_err_count=1. The next good frame is emitted with seq 0.
4. Frame of 70 words, tlast on word 69 -> len_err_count=1, no packet. The following 64-word frame is emitted intact.
5. tready toggled randomly 50% over 20 frames -> every accepted frame emitted once, in order, data matching, tdata/tlast stable while stalled, seq increments by 1 per packet.
6. Assert s00_axis_aresetn low mid-payload -> tvalid=0 immediately, counters 0. The next full frame emits header 32'hC5A10000.
